coin_feeder: RTL



---
 rtl/coin_feeder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/coin_feeder.sv
// Coin-interface driver: splits a requested amount into i/j coin strobes for the
// vending machine and counts its x (vend) / y (change) responses per request.
module coin_feeder #(
    parameter int unsigned AMT_W        = 5,
    parameter int unsigned GAP_CYCLES   = 1,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    input  logic             req_prefer_two,
    output logic             req_ready,
    output logic             i,
    output logic             j,
    input  logic             x,
    input  logic             y,
    output logic             done,
    output logic [CNT_W-1:0] vend_cnt,
    output logic [CNT_W-1:0] change_cnt,
    output logic [CNT_W-1:0] coin_cnt
);

    localparam int unsigned WAIT_MAX = (GAP_CYCLES > DRAIN_CYCLES) ? GAP_CYCLES : DRAIN_CYCLES;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        COIN,
        GAP,
        DRAIN,
        DONE
    } state_t;

    state_t             r_state;
    logic               r_i;
    logic               r_j;
    logic               r_done;
    logic               r_prefer;
    logic [AMT_W-1:0]   r_rem;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_vend;
    logic [CNT_W-1:0]   r_change;
    logic [CNT_W-1:0]   r_coin;
    logic               w_sampling;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign w_sampling = (r_state == COIN) || (r_state == GAP) || (r_state == DRAIN);

    // i/j are set on the edge that enters COIN so the strobe lines up with that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_i      <= 1'b0;
            r_j      <= 1'b0;
            r_done   <= 1'b0;
            r_prefer <= 1'b0;
            r_rem    <= '0;
            r_wait   <= '0;
            r_vend   <= '0;
            r_change <= '0;
            r_coin   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_sampling) begin
                if (x) r_vend   <= sat_inc(r_vend);
                if (y) r_change <= sat_inc(r_change);
            end
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_rem    <= req_amount;
                        r_prefer <= req_prefer_two;
                        r_vend   <= '0;
                        r_change <= '0;
                        r_coin   <= '0;
                        if (req_amount == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= COIN;
                            r_i     <= 1'b1;
                            r_j     <= req_prefer_two && (req_amount >= AMT_W'(2));
                        end
                    end
                end
                COIN: begin
                    r_rem   <= r_rem - (r_j ? AMT_W'(2) : AMT_W'(1));
                    r_coin  <= sat_inc(r_coin);
                    r_i     <= 1'b0;
                    r_j     <= 1'b0;
                    r_wait  <= WAIT_W'(GAP_CYCLES);
                    r_state <= GAP;
                end
                GAP: begin
                    if (r_wait == WAIT_W'(1)) begin
                        if (r_rem != '0) begin
                            r_state <= COIN;
                            r_i     <= 1'b1;
                            r_j     <= r_prefer && (r_rem >= AMT_W'(2));
                        end else if (DRAIN_CYCLES == 0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                            r_wait  <= WAIT_W'(DRAIN_CYCLES);
                        end
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_wait == WAIT_W'(1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_i     <= 1'b0;
                    r_j     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign i          = r_i;
    assign j          = r_j;
    assign done       = r_done;
    assign vend_cnt   = r_vend;
    assign change_cnt = r_change;
    assign coin_cnt   = r_coin;

endmodule
